// File: rtl/shift_xor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_xor_pkg
// Description : Shared constants and state type for the shift/xor decoder
//               and its paired encoder benches.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_xor_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int BYTE_W        = 8;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } sxd_state_e;

endpackage : shift_xor_pkg
`default_nettype wire

// File: rtl/sxd_deser.sv
`default_nettype none
// ============================================================================
// Module      : sxd_deser
// Description : Collects recovered bits into bytes, first bit in bit 0, and
//               emits a one-cycle byte_valid_o with each completed byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sxd_deser
    import shift_xor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_i,
    input  logic              valid_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o
);

    localparam int CNT_W = $clog2(BYTE_W);

    logic [CNT_W-1:0]  cnt_q;
    logic [BYTE_W-1:0] sr_q;
    logic [BYTE_W-1:0] sr_d;
    logic [BYTE_W-1:0] byte_q;
    logic              byte_valid_q;

    // Partial byte with the incoming bit placed at its group position.
    always_comb begin
        sr_d        = sr_q;
        sr_d[cnt_q] = bit_i;
    end

    // Bit counter, partial byte and completed-byte register with its pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sr_q         <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (valid_i) begin
                sr_q  <= sr_d;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                    byte_q       <= sr_d;
                    byte_valid_q <= 1'b1;
                end
            end
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;

endmodule : sxd_deser
`default_nettype wire

// File: rtl/shift_xor_decoder.sv
`default_nettype none
// ============================================================================
// Module      : shift_xor_decoder
// Description : Inverts a WIDTH-stage shift/xor serial encoder using a copy
//               of the key history and its running parity, then deserializes
//               the recovered bits into bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_xor_decoder
    import shift_xor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_in,
    input  logic              xor_in,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid
);

    localparam int FILL_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  hist_q;
    logic [WIDTH-1:0]  hist_d;
    logic              par_q;
    logic              par_d;
    sxd_state_e        state_q;
    logic [FILL_W-1:0] fill_cnt_q;
    logic              bit_q;
    logic              bit_valid_q;
    logic              bit_d;
    logic              bit_valid_d;

    // hist_q[0] is the previous key bit, hist_q[WIDTH-1] the oldest one.
    // Parity tracks the XOR of hist_q incrementally: add the new key bit and
    // drop the one falling off the end, so no wide XOR tree is needed.
    assign hist_d = {hist_q[WIDTH-2:0], xor_in};
    assign par_d  = par_q ^ xor_in ^ hist_q[WIDTH-1];

    // Bit and valid as they will be registered this edge; the deserializer
    // consumes these so its byte pulse lines up with the bit's valid.
    assign bit_valid_d = (state_q == ST_RUN);
    assign bit_d       = bit_valid_d & (enc_in ^ par_q);

    // Key history and its parity advance every cycle, in FILL and RUN alike.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
            par_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            par_q  <= par_d;
        end
    end

    // FILL waits WIDTH edges for the key history (and the encoder pipeline)
    // to be fully populated; RUN then emits one recovered bit per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    bit_q       <= 1'b0;
                    bit_valid_q <= 1'b0;
                    if (fill_cnt_q == FILL_W'(WIDTH - 1)) begin
                        fill_cnt_q <= FILL_W'(WIDTH);
                        state_q    <= ST_RUN;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + FILL_W'(1);
                    end
                end
                ST_RUN: begin
                    bit_q       <= bit_d;
                    bit_valid_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_FILL;
                    bit_q       <= 1'b0;
                    bit_valid_q <= 1'b0;
                end
            endcase
        end
    end

    sxd_deser u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_i        (bit_d),
        .valid_i      (bit_valid_d),
        .byte_o       (byte_out),
        .byte_valid_o (byte_valid)
    );

    assign bit_out   = bit_q;
    assign bit_valid = bit_valid_q;

endmodule : shift_xor_decoder
`default_nettype wire

// File: doc/shift_xor_decoder.md
SHIFT_XOR_DECODER -- requirements
Module: shift_xor_decoder

Interface
REQ-001 Parameter: WIDTH, default 8, number of xor stages in the paired upstream encoder; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: enc_in  input  1  encoded serial bit from the upstream shift/xor encoder output.
REQ-005 Port: xor_in  input  1  key bit, the same signal that drives the encoder in the same cycle.
REQ-006 Port: bit_out  output  1  recovered data bit.
REQ-007 Port: bit_valid  output  1  bit_out holds a recovered bit this cycle.
REQ-008 Port: byte_out  output  8  last 8 recovered bits, first-received bit in bit 0.
REQ-009 Port: byte_valid  output  1  single-cycle pulse: byte_out updated this cycle.

Function
REQ-010 Encoder model: enc(t) = d(t-WIDTH) ^ x(t-1) ^ ... ^ x(t-WIDTH); the block SHALL invert it.
REQ-011 History: each edge, hist <= {hist[WIDTH-2:0], xor_in}, so hist[0]=x(t-1) and hist[WIDTH-1]=x(t-WIDTH).
REQ-012 Parity: the block SHALL hold par = XOR of hist, updated incrementally as par <= par ^ xor_in ^ hist[WIDTH-1]; no WIDTH-input XOR tree on the output path.
REQ-013 States: FILL, RUN. FILL counts edges in fill_cnt (0..WIDTH); when fill_cnt reaches WIDTH the state moves to RUN; RUN is held until reset.
REQ-014 In RUN, each edge: bit_out <= enc_in ^ par and bit_valid <= 1. Latency is 1 cycle from enc_in; bit_out = d(t-WIDTH) for the enc_in sampled at edge t.
REQ-015 In FILL: bit_valid = 0 and bit_out = 0. History and parity still update.
REQ-016 First valid bit: the first rising edge with rst_n high is edge 0. bit_valid is first 1 after edge WIDTH, which is exactly WIDTH+1 edges after reset release.
REQ-017 Deserializer: a 3-bit counter counts valid bits and wraps 7 to 0. Recovered bit k of a group goes to byte position k.
REQ-018 On the edge that produces the 8th bit of a group: byte_out <= the full group, byte_valid <= 1 for exactly one cycle, coincident with that bit's bit_valid.
REQ-019 byte_out holds its value between pulses. Byte framing starts at the first valid bit after reset, independent of WIDTH.
REQ-020 The block has no backpressure and no enable; it consumes one bit per clock.

Reset
REQ-021 When rst_n is low at an edge: hist=0, par=0, fill_cnt=0, state=FILL, bit counter=0, bit_out=0, bit_valid=0, byte_out=0x00, byte_valid=0.
REQ-022 Reset mid-operation SHALL discard any partial byte and restart FILL. A full WIDTH-edge fill is required again before bit_valid.
REQ-023 Because the encoder itself has no reset, the FILL period SHALL also cover the encoder's WIDTH-cycle flush when both start together.

Structure
REQ-024 Package shift_xor_pkg SHALL hold DEFAULT_WIDTH=8, BYTE_W=8, and the FILL/RUN state enum, shared with encoder benches.
REQ-025 Sub-module sxd_deser (bit counter, byte shift register, byte_valid pulse) SHALL be the only sub-module; the top holds history, parity and the FSM.

Verification
REQ-026 Reset: hold rst_n low 3 cycles with random inputs -> all outputs 0; release -> bit_valid stays 0 for edges 0..7 and rises after edge 8 (WIDTH=8).
REQ-027 Zero key: xor_in=0, enc_in = 1,0,1,1 from edge 8 -> bit_out = 1,0,1,1 one cycle later with bit_valid=1.
REQ-028 Key impulse: enc_in=0 and xor_in=1 only at edge 10 -> bit_out=1 after edges 11..18 and 0 after all other RUN edges.
REQ-029 End-to-end: the paired 8-stage encoder and the decoder share clk and xor_in (LFSR, seed 0xB5); encoder data starts at edge 0 as 0xA5 then 0x3C, LSB first -> first two byte_valid pulses carry byte_out=0xA5 then 0x3C, and 1000 random bits match with zero mismatches.
REQ-030 Mid-byte reset: rst_n low for 1 edge after 5 valid bits -> no byte_valid pulse; next bit_valid comes 9 edges after release; the first byte after it is the next 8 bits, with no carry-over of the partial byte.
REQ-031 Generic: WIDTH=3 and WIDTH=16 with the end-to-end stimulus -> zero mismatches, and the first bit_valid comes after edge WIDTH.
